// File: rtl/falafel_mem_arbiter.sv
// falafel_mem_arbiter
//
// Shares one falafel memory port between NUM_REQ requesters (index 0 is the
// falafel core, the rest are host/debug style ports). Requests are granted
// round-robin and forwarded combinationally, so the arbiter adds no latency.
// Memory answers every accepted request exactly once and strictly in order.
// An in-order tag FIFO remembers which requester issued each in-flight
// transaction, and each memory response is steered back to that requester.
//
// Ports
//   clk_i, rst_i              clock, asynchronous active-high reset
//   req_val_i / req_rdy_o     per-requester request handshake
//   req_is_write_i            per-requester 1 = write, 0 = read
//   req_addr_i, req_data_i    per-requester address and write data
//   rsp_val_o / rsp_rdy_i     per-requester response handshake
//   rsp_data_o                response data, broadcast, qualified by rsp_val_o
//   mem_req_*                 request channel towards memory
//   mem_rsp_*                 response channel from memory
//   outstanding_o             number of in-flight transactions (FIFO count)
//   err_unexpected_rsp_o      sticky: memory responded with nothing in flight

module falafel_mem_arbiter #(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned DATA_W          = 64,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned IDX_W           = $clog2(NUM_REQ)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,

    // Requester side
    input  logic [NUM_REQ-1:0]             req_val_i,
    output logic [NUM_REQ-1:0]             req_rdy_o,
    input  logic [NUM_REQ-1:0]             req_is_write_i,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_addr_i,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]             rsp_val_o,
    input  logic [NUM_REQ-1:0]             rsp_rdy_i,
    output logic [DATA_W-1:0]              rsp_data_o,

    // Memory request channel
    output logic                           mem_req_val_o,
    input  logic                           mem_req_rdy_i,
    output logic                           mem_req_is_write_o,
    output logic [DATA_W-1:0]              mem_req_addr_o,
    output logic [DATA_W-1:0]              mem_req_data_o,

    // Memory response channel
    input  logic                           mem_rsp_val_i,
    output logic                           mem_rsp_rdy_o,
    input  logic [DATA_W-1:0]              mem_rsp_data_i,

    // Status
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o,
    output logic                           err_unexpected_rsp_o
);

    localparam int unsigned PtrW = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CntW = PtrW + 1;
    // One extra bit so rr_ptr + offset can exceed NUM_REQ before folding.
    localparam int unsigned SumW = IDX_W + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] tag_mem_q [MAX_OUTSTANDING];

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic             fifo_full;
    logic             fifo_empty;
    logic [IDX_W-1:0] head_idx;

    logic             arb_found;
    logic [IDX_W-1:0] arb_idx;
    logic [SumW-1:0]  cand_sum;

    logic             grant_val;
    logic [IDX_W-1:0] grant_idx;

    // Request/response qualifiers before reset gating. These feed the state
    // update; only the port outputs are gated by rst_i.
    logic             req_fwd;
    logic             rsp_acc;
    logic             push;
    logic             pop;

    assign fifo_full  = (count_q == CntW'(MAX_OUTSTANDING));
    assign fifo_empty = (count_q == '0);
    assign head_idx   = tag_mem_q[rd_ptr_q];

    // Round-robin search: first valid requester at or after rr_ptr_q,
    // wrapping modulo NUM_REQ (NUM_REQ need not be a power of two).
    always_comb begin : arb_search
        arb_found = 1'b0;
        arb_idx   = '0;
        cand_sum  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand_sum = SumW'(rr_ptr_q) + SumW'(i);
            if (cand_sum >= SumW'(NUM_REQ)) begin
                cand_sum = cand_sum - SumW'(NUM_REQ);
            end
            if (!arb_found && req_val_i[cand_sum[IDX_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand_sum[IDX_W-1:0];
            end
        end
    end

    // A stalled request keeps its grant so memory sees a stable request.
    assign grant_idx = lock_q ? lock_idx_q : arb_idx;
    assign grant_val = lock_q ? req_val_i[lock_idx_q] : arb_found;

    // Push is refused while full even if a pop happens in the same cycle,
    // which keeps the full flag independent of the response path.
    assign req_fwd = grant_val & ~fifo_full;
    assign push    = req_fwd & mem_req_rdy_i;
    assign rsp_acc = ~fifo_empty & rsp_rdy_i[head_idx];
    assign pop     = mem_rsp_val_i & rsp_acc;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin : state_reg
        if (rst_i) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_q      <= err_d;
        end
    end

    // Tag storage needs no reset: entries are only read while count_q > 0.
    always_ff @(posedge clk_i) begin : tag_store
        if (push) begin
            tag_mem_q[wr_ptr_q] <= grant_idx;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin : next_state
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        err_d      = err_q;

        // Round-robin pointer moves past the requester just served.
        if (push) begin
            if (grant_idx == IDX_W'(NUM_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + IDX_W'(1);
            end
        end

        // Lock on a presented-but-stalled request, release on handshake.
        if (push) begin
            lock_d = 1'b0;
        end else if (req_fwd && !mem_req_rdy_i) begin
            lock_d     = 1'b1;
            lock_idx_d = grant_idx;
        end

        // Tag FIFO pointers wrap naturally; the count is kept separately.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        if (mem_rsp_val_i && fifo_empty) begin
            err_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Handshake outputs are forced low while rst_i is asserted so the
    // reset values appear immediately, even with requesters still valid.
    always_comb begin : outputs
        req_rdy_o = '0;
        rsp_val_o = '0;

        if (req_fwd && mem_req_rdy_i && !rst_i) begin
            req_rdy_o[grant_idx] = 1'b1;
        end
        if (mem_rsp_val_i && !fifo_empty && !rst_i) begin
            rsp_val_o[head_idx] = 1'b1;
        end

        mem_req_val_o      = req_fwd & ~rst_i;
        mem_req_is_write_o = req_is_write_i[grant_idx];
        mem_req_addr_o     = req_addr_i[grant_idx];
        mem_req_data_o     = req_data_i[grant_idx];

        mem_rsp_rdy_o      = rsp_acc & ~rst_i;
        rsp_data_o         = mem_rsp_data_i;

        outstanding_o        = count_q;
        err_unexpected_rsp_o = err_q;
    end

endmodule

// File: tb/tb_falafel_mem_arbiter.sv
// Self-checking bench for falafel_mem_arbiter (2 requesters, 4-deep tag FIFO).
// Requester pushes an expected {owner, data} into a scoreboard on each
// request handshake; a small in-order memory model answers with data derived
// from the request it saw; each routed response pops and checks the board.

module tb_falafel_mem_arbiter;

    localparam int unsigned NumReq = 2;
    localparam int unsigned DataW  = 64;
    localparam int unsigned MaxOut = 4;
    localparam int unsigned Big    = 1000000;

    logic                          clk_i;
    logic                          rst_i;
    logic [NumReq-1:0]             req_val_i;
    logic [NumReq-1:0]             req_rdy_o;
    logic [NumReq-1:0]             req_is_write_i;
    logic [NumReq-1:0][DataW-1:0]  req_addr_i;
    logic [NumReq-1:0][DataW-1:0]  req_data_i;
    logic [NumReq-1:0]             rsp_val_o;
    logic [NumReq-1:0]             rsp_rdy_i;
    logic [DataW-1:0]              rsp_data_o;
    logic                          mem_req_val_o;
    logic                          mem_req_rdy_i;
    logic                          mem_req_is_write_o;
    logic [DataW-1:0]              mem_req_addr_o;
    logic [DataW-1:0]              mem_req_data_o;
    logic                          mem_rsp_val_i;
    logic                          mem_rsp_rdy_o;
    logic [DataW-1:0]              mem_rsp_data_i;
    logic [$clog2(MaxOut):0]       outstanding_o;
    logic                          err_unexpected_rsp_o;

    falafel_mem_arbiter #(
        .NUM_REQ         (NumReq),
        .DATA_W          (DataW),
        .MAX_OUTSTANDING (MaxOut)
    ) dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .req_val_i            (req_val_i),
        .req_rdy_o            (req_rdy_o),
        .req_is_write_i       (req_is_write_i),
        .req_addr_i           (req_addr_i),
        .req_data_i           (req_data_i),
        .rsp_val_o            (rsp_val_o),
        .rsp_rdy_i            (rsp_rdy_i),
        .rsp_data_o           (rsp_data_o),
        .mem_req_val_o        (mem_req_val_o),
        .mem_req_rdy_i        (mem_req_rdy_i),
        .mem_req_is_write_o   (mem_req_is_write_o),
        .mem_req_addr_o       (mem_req_addr_o),
        .mem_req_data_o       (mem_req_data_o),
        .mem_rsp_val_i        (mem_rsp_val_i),
        .mem_rsp_rdy_o        (mem_rsp_rdy_o),
        .mem_rsp_data_i       (mem_rsp_data_i),
        .outstanding_o        (outstanding_o),
        .err_unexpected_rsp_o (err_unexpected_rsp_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        int unsigned idx;
        logic [63:0] data;
    } sb_t;

    typedef struct {
        logic [63:0] data;
        int unsigned due;
    } mem_t;

    sb_t         sb_q[$];
    mem_t        mem_q[$];
    int unsigned grants_q[$];

    int unsigned n_checks;
    int unsigned n_errors;
    int unsigned cycle;
    int unsigned mem_lat;
    int unsigned mem_credit;
    logic        mem_inject;
    int unsigned rq_left  [NumReq];
    int unsigned rq_seq   [NumReq];
    logic        rq_write [NumReq];
    logic [63:0] lock_addr;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Memory response data depends on everything the memory was handed.
    function automatic logic [63:0] mem_f(input logic w, input logic [63:0] a,
                                          input logic [63:0] d);
        return a ^ 64'hC3A5_0F0F_5A5A_9669 ^ (w ? d : 64'h0);
    endfunction

    task automatic drive_req();
        for (int i = 0; i < NumReq; i++) begin
            req_val_i[i]      = (rq_left[i] > 0);
            req_is_write_i[i] = rq_write[i];
            req_addr_i[i]     = (64'(i) << 56) | (64'(rq_seq[i]) << 3);
            req_data_i[i]     = ~req_addr_i[i] ^ 64'h1111;
        end
    endtask

    task automatic mem_drive();
        if (mem_inject) begin
            mem_rsp_val_i  = 1'b1;
            mem_rsp_data_i = 64'hDEAD_BEEF_0BAD_F00D;
        end else if (mem_q.size() > 0 && mem_q[0].due <= cycle && mem_credit > 0) begin
            mem_rsp_val_i  = 1'b1;
            mem_rsp_data_i = mem_q[0].data;
        end else begin
            mem_rsp_val_i  = 1'b0;
            mem_rsp_data_i = '0;
        end
    endtask

    // One clock: observe handshakes, advance, then redrive requesters/memory.
    task automatic step();
        logic [NumReq-1:0] hs;
        sb_t  e;
        mem_t m;
        #1;
        hs = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (req_val_i[i] && req_rdy_o[i]) begin
                hs[i]  = 1'b1;
                e.idx  = i;
                e.data = mem_f(req_is_write_i[i], req_addr_i[i], req_data_i[i]);
                sb_q.push_back(e);
                grants_q.push_back(i);
            end
        end
        if (mem_req_val_o && mem_req_rdy_i) begin
            m.data = mem_f(mem_req_is_write_o, mem_req_addr_o, mem_req_data_o);
            m.due  = cycle + mem_lat;
            mem_q.push_back(m);
        end
        for (int i = 0; i < NumReq; i++) begin
            if (rsp_val_o[i] && rsp_rdy_i[i]) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_underflow", 64'(sb_q.size()), 64'd1);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("rsp_owner", 64'(i), 64'(e.idx));
                    check_eq("rsp_data", rsp_data_o, e.data);
                end
            end
        end
        if (mem_rsp_val_i && mem_rsp_rdy_o && mem_q.size() > 0) begin
            mem_q.delete(0);
            if (mem_credit > 0) mem_credit--;
        end
        @(posedge clk_i);
        #1;
        cycle++;
        for (int i = 0; i < NumReq; i++) begin
            if (hs[i]) begin
                rq_seq[i]++;
                rq_left[i]--;
            end
        end
        drive_req();
        mem_drive();
    endtask

    function automatic logic busy();
        return (rq_left[0] > 0) || (rq_left[1] > 0) || (sb_q.size() > 0) || (mem_q.size() > 0);
    endfunction

    task automatic run_until_idle(input string tag, input int unsigned budget);
        int unsigned n;
        n = 0;
        while (busy() && n < budget) begin
            step();
            n++;
        end
        check_eq(tag, {63'b0, busy()}, 64'd0);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_mem_req_val"}, {63'b0, mem_req_val_o}, 64'd0);
        check_eq({tag, "_req_rdy"}, 64'(req_rdy_o), 64'd0);
        check_eq({tag, "_rsp_val"}, 64'(rsp_val_o), 64'd0);
        check_eq({tag, "_mem_rsp_rdy"}, {63'b0, mem_rsp_rdy_o}, 64'd0);
        check_eq({tag, "_outstanding"}, 64'(outstanding_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        cycle      = 0;
        mem_lat    = 2;
        mem_credit = Big;
        mem_inject = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            rq_left[i]  = 0;
            rq_seq[i]   = 0;
            rq_write[i] = 1'b0;
        end
        rst_i         = 1'b1;
        rsp_rdy_i     = '1;
        mem_req_rdy_i = 1'b1;
        drive_req();
        mem_drive();

        // Reset state
        #1;
        check_quiet("reset");
        check_eq("reset_err", {63'b0, err_unexpected_rsp_o}, 64'd0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Round-robin: both requesters streaming, requester 1 writes
        grants_q.delete();
        rq_write[1] = 1'b1;
        rq_left[0]  = 4;
        rq_left[1]  = 4;
        drive_req();
        run_until_idle("rr_drain", 100);
        check_eq("rr_grant_count", 64'(grants_q.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < grants_q.size()) check_eq("rr_grant_order", 64'(grants_q[i]), 64'(i % 2));
        end
        check_eq("rr_outstanding", 64'(outstanding_o), 64'd0);
        rq_write[1] = 1'b0;

        // Lock under backpressure
        mem_req_rdy_i = 1'b0;
        rq_left[1]    = 1;
        drive_req();
        lock_addr = req_addr_i[1];
        #1;
        check_eq("lock_val", {63'b0, mem_req_val_o}, 64'd1);
        check_eq("lock_addr0", mem_req_addr_o, lock_addr);
        step();
        rq_left[0] = 1;
        drive_req();
        for (int k = 0; k < 2; k++) begin
            #1;
            check_eq("lock_addr_stall", mem_req_addr_o, lock_addr);
            check_eq("lock_rdy_stall", 64'(req_rdy_o), 64'd0);
            step();
        end
        mem_req_rdy_i = 1'b1;
        #1;
        check_eq("lock_rdy_release", 64'(req_rdy_o), 64'b10);
        step();
        #1;
        check_eq("lock_next_grant", 64'(req_rdy_o), 64'b01);
        check_eq("lock_next_addr", mem_req_addr_o, req_addr_i[0]);
        run_until_idle("lock_drain", 50);

        // Full FIFO: 6 reads, memory withholds responses
        grants_q.delete();
        mem_credit = 0;
        rq_left[0] = 6;
        drive_req();
        for (int k = 0; k < 8; k++) step();
        #1;
        check_eq("full_accepted", 64'(grants_q.size()), 64'd4);
        check_eq("full_outstanding", 64'(outstanding_o), 64'd4);
        check_eq("full_mem_req_val", {63'b0, mem_req_val_o}, 64'd0);
        check_eq("full_req_rdy", 64'(req_rdy_o), 64'd0);
        mem_credit = 1;
        mem_drive();
        #1;
        check_eq("full_pop_rdy", {63'b0, mem_rsp_rdy_o}, 64'd1);
        check_eq("full_push_blocked", {63'b0, mem_req_val_o}, 64'd0);
        step();
        #1;
        check_eq("full_after_pop_cnt", 64'(outstanding_o), 64'd3);
        check_eq("full_after_pop_val", {63'b0, mem_req_val_o}, 64'd1);
        check_eq("full_after_pop_rdy", 64'(req_rdy_o), 64'b01);
        step();
        #1;
        check_eq("full_refill_cnt", 64'(outstanding_o), 64'd4);
        mem_credit = Big;
        mem_drive();
        run_until_idle("full_drain", 60);

        // Response backpressure on requester 1
        rsp_rdy_i  = 2'b01;
        rq_left[1] = 1;
        drive_req();
        for (int n = 0; n < 20 && !mem_rsp_val_i; n++) step();
        check_eq("bp_rsp_arrived", {63'b0, mem_rsp_val_i}, 64'd1);
        for (int k = 0; k < 2; k++) begin
            #1;
            check_eq("bp_mem_rsp_rdy", {63'b0, mem_rsp_rdy_o}, 64'd0);
            check_eq("bp_rsp_val", 64'(rsp_val_o), 64'b10);
            check_eq("bp_outstanding", 64'(outstanding_o), 64'd1);
            step();
        end
        rsp_rdy_i = 2'b11;
        #1;
        check_eq("bp_release_rdy", {63'b0, mem_rsp_rdy_o}, 64'd1);
        step();
        #1;
        check_eq("bp_popped", 64'(outstanding_o), 64'd0);
        check_eq("bp_sb_empty", 64'(sb_q.size()), 64'd0);

        // Unexpected response with nothing in flight
        check_eq("unexp_err_before", {63'b0, err_unexpected_rsp_o}, 64'd0);
        mem_inject = 1'b1;
        mem_drive();
        #1;
        check_eq("unexp_mem_rsp_rdy", {63'b0, mem_rsp_rdy_o}, 64'd0);
        check_eq("unexp_rsp_val", 64'(rsp_val_o), 64'd0);
        step();
        mem_inject = 1'b0;
        mem_drive();
        #1;
        check_eq("unexp_err_set", {63'b0, err_unexpected_rsp_o}, 64'd1);
        step();
        step();
        check_eq("unexp_err_sticky", {63'b0, err_unexpected_rsp_o}, 64'd1);

        // Asynchronous reset in the middle of a stall
        mem_credit = 0;
        rq_left[0] = 2;
        drive_req();
        for (int k = 0; k < 3; k++) step();
        check_eq("arst_pre_outstanding", 64'(outstanding_o), 64'd2);
        mem_req_rdy_i = 1'b0;
        rq_left[1]    = 1;
        drive_req();
        step();
        mem_credit = 1;
        mem_drive();
        #1;
        check_eq("arst_pre_rsp_val", 64'(rsp_val_o), 64'b01);
        check_eq("arst_pre_req_val", {63'b0, mem_req_val_o}, 64'd1);
        #1;
        rst_i = 1'b1;
        #1;
        check_quiet("arst");
        check_eq("arst_err", {63'b0, err_unexpected_rsp_o}, 64'd0);
        sb_q.delete();
        mem_q.delete();
        rq_left[0]    = 0;
        rq_left[1]    = 0;
        mem_credit    = Big;
        mem_inject    = 1'b0;
        mem_req_rdy_i = 1'b1;
        drive_req();
        mem_drive();
        #1;
        rst_i = 1'b0;
        #1;
        check_eq("arst_post_err", {63'b0, err_unexpected_rsp_o}, 64'd0);
        check_eq("arst_post_outstanding", 64'(outstanding_o), 64'd0);
        rq_left[0] = 1;
        rq_left[1] = 1;
        drive_req();
        #1;
        check_eq("arst_rr_ptr_reset", 64'(req_rdy_o), 64'b01);
        run_until_idle("arst_drain", 50);
        check_eq("final_err", {63'b0, err_unexpected_rsp_o}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
